// File: rtl/perf_counter_bank.sv
// Bank of per-channel event counters plus a run-cycle counter, with snapshot
// shadow registers for coherent readout and an IDLE/RUN/FROZEN control FSM.
module perf_counter_bank #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SAT_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         halt,
    input  logic                         clear,
    input  logic [NUM_CH-1:0]            event_vec,
    input  logic                         snap_req,
    output logic                         snap_ack,
    input  logic [$clog2(NUM_CH+1)-1:0]  rd_sel,
    output logic [CNT_W-1:0]             rd_data,
    output logic [NUM_CH:0]              ovf,
    output logic [1:0]                   state
);

    localparam int unsigned NCNT  = NUM_CH + 1;
    localparam int unsigned SEL_W = $clog2(NUM_CH + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_d, state_q;
    logic [CNT_W-1:0] cnt_d [NCNT];
    logic [CNT_W-1:0] cnt_q [NCNT];
    logic [CNT_W-1:0] shd_d [NCNT];
    logic [CNT_W-1:0] shd_q [NCNT];
    logic [NUM_CH:0]  ovf_d, ovf_q;
    logic [NUM_CH:0]  inc_c;
    logic             snap_ack_d, snap_ack_q;
    logic [CNT_W-1:0] rd_data_d, rd_data_q;

    // Control FSM next state; clear overrides every other request.
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_RUN;
            ST_RUN:    if (halt)  state_d = ST_FROZEN;
            ST_FROZEN: if (start) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    // Counter, overflow and shadow update; the top counter slot counts RUN cycles.
    always_comb begin : count_next
        cnt_d = cnt_q;
        shd_d = shd_q;
        ovf_d = ovf_q;
        inc_c = (state_q == ST_RUN) ? {1'b1, event_vec} : '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (inc_c[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                    if (SAT_MODE == 0) begin
                        cnt_d[i] = '0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Shadows take the post-increment values so same-cycle events are captured.
        if (snap_req) begin
            shd_d = cnt_d;
        end
        if (clear) begin
            for (int unsigned i = 0; i < NCNT; i++) begin
                cnt_d[i] = '0;
                shd_d[i] = '0;
            end
            ovf_d = '0;
        end
    end

    // Shadow read mux; out-of-range selects return zero.
    always_comb begin : rd_next
        rd_data_d = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_data_d = shd_q[i];
            end
        end
    end

    assign snap_ack_d = snap_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ovf_q      <= '0;
            snap_ack_q <= 1'b0;
            rd_data_q  <= '0;
            for (int unsigned i = 0; i < NCNT; i++) begin
                cnt_q[i] <= '0;
                shd_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            snap_ack_q <= snap_ack_d;
            rd_data_q  <= rd_data_d;
            for (int unsigned i = 0; i < NCNT; i++) begin
                cnt_q[i] <= cnt_d[i];
                shd_q[i] <= shd_d[i];
            end
        end
    end

    assign state    = state_q;
    assign ovf      = ovf_q;
    assign snap_ack = snap_ack_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed + random check of perf_counter_bank (wrap and saturate instances)
// against an arithmetic reference model.
module tb_perf_counter_bank;

    localparam int NCH  = 8;
    localparam int CW   = 8;
    localparam int MAXV = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, halt = 1'b0, clear = 1'b0, snap_req = 1'b0;
    logic [NCH-1:0] event_vec = '0;
    logic [3:0]    rd_sel = '0;

    logic          ack_w, ack_s;
    logic [CW-1:0] rd_w, rd_s;
    logic [NCH:0]  ovf_w, ovf_s;
    logic [1:0]    st_w, st_s;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SAT_MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
        .event_vec(event_vec), .snap_req(snap_req), .snap_ack(ack_w),
        .rd_sel(rd_sel), .rd_data(rd_w), .ovf(ovf_w), .state(st_w)
    );

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SAT_MODE(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
        .event_vec(event_vec), .snap_req(snap_req), .snap_ack(ack_s),
        .rd_sel(rd_sel), .rd_data(rd_s), .ovf(ovf_s), .state(st_s)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 run, 2 frozen; index NCH is the cycle count.
    int         mode;
    int         mw  [NCH+1];
    int         ms  [NCH+1];
    int         shw [NCH+1];
    int         shs [NCH+1];
    logic [NCH:0] mow, mos;
    logic       exp_ack;
    int         exp_rdw, exp_rds;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = 0;
        for (int i = 0; i <= NCH; i++) begin
            mw[i] = 0; ms[i] = 0; shw[i] = 0; shs[i] = 0;
        end
        mow = '0; mos = '0;
        exp_ack = 1'b0; exp_rdw = 0; exp_rds = 0;
    endtask

    task automatic model_edge();
        int r;
        r = int'(rd_sel);
        exp_rdw = (r <= NCH) ? shw[r] : 0;
        exp_rds = (r <= NCH) ? shs[r] : 0;
        exp_ack = snap_req;
        if (clear) begin
            mode = 0;
            for (int i = 0; i <= NCH; i++) begin
                mw[i] = 0; ms[i] = 0; shw[i] = 0; shs[i] = 0;
            end
            mow = '0; mos = '0;
        end else begin
            if (mode == 1) begin
                for (int i = 0; i <= NCH; i++) begin
                    if (i == NCH || event_vec[i]) begin
                        mw[i] = (mw[i] + 1) % (MAXV + 1);
                        if (mw[i] == 0) mow[i] = 1'b1;
                        if (ms[i] + 1 > MAXV) mos[i] = 1'b1;
                        else ms[i] = ms[i] + 1;
                    end
                end
            end
            if (snap_req) begin
                shw = mw;
                shs = ms;
            end
            if (mode == 0 && start) mode = 1;
            else if (mode == 1 && halt) mode = 2;
            else if (mode == 2 && start) mode = 1;
        end
    endtask

    task automatic check_all();
        chk("state_w", 64'(st_w), 64'(mode));
        chk("state_s", 64'(st_s), 64'(mode));
        chk("ack_w", 64'(ack_w), 64'(exp_ack));
        chk("ack_s", 64'(ack_s), 64'(exp_ack));
        chk("ovf_w", 64'(ovf_w), 64'(mow));
        chk("ovf_s", 64'(ovf_s), 64'(mos));
        chk("rd_w", 64'(rd_w), 64'(exp_rdw));
        chk("rd_s", 64'(rd_s), 64'(exp_rds));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_in();
        start = 1'b0; halt = 1'b0; clear = 1'b0; snap_req = 1'b0; event_vec = '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_state"}, 64'(st_w), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf_w), 64'd0);
        chk({tag, "_rd"}, 64'(rd_w), 64'd0);
        chk({tag, "_ack"}, 64'(ack_w), 64'd0);
        chk({tag, "_rd_s"}, 64'(rd_s), 64'd0);
    endtask

    initial begin
        model_reset();
        idle_in();
        #1 rst = 1'b0;
        #1 check_zero_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle after reset: no counting without start.
        event_vec = '1;
        repeat (3) step();
        idle_in();

        // Ten events on ch0, then halt; cycle count includes the halt cycle.
        start = 1'b1; step(); start = 1'b0;
        event_vec = 8'h01;
        repeat (10) step();
        event_vec = '0;
        halt = 1'b1; step(); halt = 1'b0;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        rd_sel = 4'd0; step();
        chk("basic_ch0", 64'(rd_w), 64'd10);
        rd_sel = 4'd8; step();
        chk("basic_cycles", 64'(rd_w), 64'd11);
        rd_sel = 4'd12; step();
        chk("sel_out_of_range", 64'(rd_w), 64'd0);

        // 257 events on ch1: wrap instance reads 1, saturating one reads 255.
        clear = 1'b1; step(); clear = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        event_vec = 8'h02;
        repeat (257) step();
        event_vec = '0;
        halt = 1'b1; step(); halt = 1'b0;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        rd_sel = 4'd1; step();
        chk("wrap_ch1", 64'(rd_w), 64'd1);
        chk("sat_ch1", 64'(rd_s), 64'd255);
        chk("wrap_ovf1", 64'(ovf_w[1]), 64'd1);
        chk("sat_ovf1", 64'(ovf_s[1]), 64'd1);
        rd_sel = 4'd8; step();
        chk("wrap_cycles", 64'(rd_w), 64'd2);
        chk("sat_cycles", 64'(rd_s), 64'd255);

        // Clear together with snapshot and start: clear wins, ack still pulses.
        clear = 1'b1; snap_req = 1'b1; start = 1'b1; event_vec = '1;
        step();
        idle_in();
        chk("clr_state", 64'(st_w), 64'd0);
        chk("clr_ack", 64'(ack_w), 64'd1);
        chk("clr_ovf", 64'(ovf_w), 64'd0);
        for (int r = 0; r <= NCH + 1; r++) begin
            rd_sel = 4'(r); step();
            if (r > 0) chk("clr_rd", 64'(rd_w), 64'd0);
        end

        // Events in IDLE do not count.
        for (int k = 0; k < 20; k++) begin
            event_vec = 8'($urandom); step();
        end
        event_vec = '0;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        rd_sel = 4'd0; step();
        chk("idle_ch0", 64'(rd_w), 64'd0);

        // Count in RUN, hold in FROZEN, resume from held values.
        start = 1'b1; step(); start = 1'b0;
        event_vec = '1;
        repeat (5) step();
        halt = 1'b1; step(); halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            event_vec = 8'($urandom); halt = 1'($urandom); step();
        end
        idle_in();
        snap_req = 1'b1; step(); snap_req = 1'b0;
        rd_sel = 4'd0; step();
        chk("frozen_ch0", 64'(rd_w), 64'd6);
        start = 1'b1; step(); start = 1'b0;
        event_vec = '1;
        repeat (3) step();
        event_vec = '0;
        start = 1'b1; step(); start = 1'b0;
        halt = 1'b1; step(); halt = 1'b0;
        snap_req = 1'b1; step(); snap_req = 1'b0;
        rd_sel = 4'd0; step();
        chk("resume_ch0", 64'(rd_w), 64'd9);

        // Back-to-back snapshots with ch2 events every cycle.
        start = 1'b1; step(); start = 1'b0;
        event_vec = 8'h04; snap_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("b2b_ack", 64'(ack_w), 64'd1);
        end
        idle_in();
        rd_sel = 4'd2; step();
        chk("b2b_ch2", 64'(rd_w), 64'd12);
        chk("b2b_ack_end", 64'(ack_w), 64'd0);

        // Asynchronous reset mid-RUN while a snapshot is requested.
        event_vec = 8'hff; snap_req = 1'b1;
        #2 rst = 1'b0;
        #1 check_zero_outputs("rst_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        idle_in();
        rst = 1'b1;
        step();
        chk("rst_no_ack", 64'(ack_w), 64'd0);
        chk("rst_idle", 64'(st_w), 64'd0);
        event_vec = '1;
        repeat (3) step();
        idle_in();
        snap_req = 1'b1; step(); snap_req = 1'b0;
        rd_sel = 4'd8; step();
        chk("rst_no_count", 64'(rd_w), 64'd0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            start     = ($urandom_range(0, 7) == 0);
            halt      = ($urandom_range(0, 9) == 0);
            clear     = ($urandom_range(0, 59) == 0);
            snap_req  = ($urandom_range(0, 3) == 0);
            event_vec = 8'($urandom);
            rd_sel    = 4'($urandom_range(0, 15));
            step();
        end
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
